// File: rtl/tape_engine_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tape_engine_if
// Purpose  : Command/response bundle for the tape engine. Holds one command
//            channel with a valid/ready handshake and a READ response channel
//            that has no backpressure.
// Signals  : cmd_valid  command present                 (master -> slave)
//            cmd_ready  engine accepts a command        (slave  -> master)
//            cmd_op     opcode, 3 bits                  (master -> slave)
//            cmd_arg    amount / distance / value       (master -> slave)
//            rsp_valid  one-cycle READ data pulse       (slave  -> master)
//            rsp_data   READ result, held between READs (slave  -> master)
// Revision : 1.0  initial release
// ============================================================================
interface tape_engine_if #(
   parameter int DATA_W = 8
) ();
   logic              cmd_valid;
   logic              cmd_ready;
   logic [2:0]        cmd_op;
   logic [DATA_W-1:0] cmd_arg;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;

   modport master (
      output cmd_valid, cmd_op, cmd_arg,
      input  cmd_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_arg,
      output cmd_ready, rsp_valid, rsp_data
   );
endinterface
`default_nettype wire

// File: rtl/tape_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tape_engine
// Purpose  : Tape datapath: cell RAM, cell pointer and a cached copy of the
//            current cell behind one command port. Supports ADD/SUB, pointer
//            moves with refetch, READ/WRITE, and a full-tape CLEAR that also
//            runs after every reset. Wrap or saturate behaviour is selectable
//            for the pointer and for cell arithmetic.
// Params   : DATA_W    cell width (and cmd_arg width)
//            ADDR_W    pointer width, DEPTH = 2**ADDR_W
//            PTR_WRAP  1 wrap pointer, 0 clamp pointer and set err
//            CELL_WRAP 1 wrap cell arithmetic, 0 saturate cell arithmetic
// Ports    : clk        clock, all state changes on the rising edge
//            rst_n      asynchronous active-low reset
//            bus        command/response interface (slave side)
//            ptr        current pointer
//            cell_zero  cached current cell is zero
//            err        sticky flag, set by a clamped pointer move
// Revision : 1.0  initial release
// ============================================================================
module tape_engine #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 8,
   parameter int PTR_WRAP  = 1,
   parameter int CELL_WRAP = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   tape_engine_if.slave      bus,
   output logic [ADDR_W-1:0] ptr,
   output logic              cell_zero,
   output logic              err
);

   localparam int DEPTH = 2 ** ADDR_W;
   // Pointer arithmetic width: wide enough for both operands plus carry/borrow.
   localparam int PW    = ((ADDR_W > DATA_W) ? ADDR_W : DATA_W) + 1;

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_ADD   = 3'd1;
   localparam logic [2:0] OP_SUB   = 3'd2;
   localparam logic [2:0] OP_RIGHT = 3'd3;
   localparam logic [2:0] OP_LEFT  = 3'd4;
   localparam logic [2:0] OP_READ  = 3'd5;
   localparam logic [2:0] OP_WRITE = 3'd6;
   localparam logic [2:0] OP_CLEAR = 3'd7;

   typedef enum logic [1:0] {
      S_CLEAR     = 2'd0,
      S_IDLE      = 2'd1,
      S_FETCH_REQ = 2'd2,
      S_FETCH_CAP = 2'd3
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] clr_addr;
   logic [ADDR_W-1:0] ptr_q;
   logic [DATA_W-1:0] cur;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] rsp_data_q;
   logic              ready_q;
   logic              rsp_valid_q;
   logic              err_q;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [DATA_W-1:0] arg;
   logic [2:0]        op;
   logic              accept;

   assign arg    = bus.cmd_arg;
   assign op     = bus.cmd_op;
   // ready_q is high exactly while the FSM sits in IDLE.
   assign accept = ready_q & bus.cmd_valid;

   // ------------------------------------------------------------------------
   // Cell arithmetic (one extra bit exposes carry / borrow)
   // ------------------------------------------------------------------------
   logic [DATA_W:0]   add_full;
   logic [DATA_W:0]   sub_full;
   logic [DATA_W-1:0] add_res;
   logic [DATA_W-1:0] sub_res;

   always_comb begin
      add_full = {1'b0, cur} + {1'b0, arg};
      sub_full = {1'b0, cur} - {1'b0, arg};
      add_res  = add_full[DATA_W-1:0];
      sub_res  = sub_full[DATA_W-1:0];
      if (CELL_WRAP == 0) begin
         if (add_full[DATA_W]) add_res = '1;
         if (sub_full[DATA_W]) sub_res = '0;
      end
   end

   // ------------------------------------------------------------------------
   // Pointer arithmetic
   // ------------------------------------------------------------------------
   logic [PW-1:0]     ptr_x;
   logic [PW-1:0]     arg_x;
   logic [PW-1:0]     right_full;
   logic [PW-1:0]     left_full;
   logic              right_oor;
   logic              left_oor;
   logic [ADDR_W-1:0] right_res;
   logic [ADDR_W-1:0] left_res;

   assign ptr_x      = {{(PW-ADDR_W){1'b0}}, ptr_q};
   assign arg_x      = {{(PW-DATA_W){1'b0}}, arg};
   assign right_full = ptr_x + arg_x;
   assign left_full  = ptr_x - arg_x;
   // Anything above the pointer range is past DEPTH-1; the top bit of the
   // difference is the borrow of a move below 0.
   assign right_oor  = |right_full[PW-1:ADDR_W];
   assign left_oor   = left_full[PW-1];

   always_comb begin
      right_res = right_full[ADDR_W-1:0];
      left_res  = left_full[ADDR_W-1:0];
      if (PTR_WRAP == 0) begin
         if (right_oor) right_res = '1;
         if (left_oor)  left_res  = '0;
      end
   end

   // ------------------------------------------------------------------------
   // RAM write port: clear sweep or write-through of the current cell
   // ------------------------------------------------------------------------
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = ptr_q;
      mem_wdata = '0;
      if (state == S_CLEAR) begin
         mem_we    = 1'b1;
         mem_waddr = clr_addr;
      end else if (accept) begin
         case (op)
            OP_ADD: begin
               mem_we    = 1'b1;
               mem_wdata = add_res;
            end
            OP_SUB: begin
               mem_we    = 1'b1;
               mem_wdata = sub_res;
            end
            OP_WRITE: begin
               mem_we    = 1'b1;
               mem_wdata = arg;
            end
            default: ;
         endcase
      end
   end

   // RAM is deliberately not reset; the clear sweep initialises it.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
      if (state == S_FETCH_REQ) rd_data <= mem[ptr_q];
   end

   // ------------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_CLEAR;
         clr_addr    <= '0;
         ptr_q       <= '0;
         cur         <= '0;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state)
            S_CLEAR: begin
               cur      <= '0;
               clr_addr <= clr_addr + 1'b1;
               if (&clr_addr) begin
                  state   <= S_IDLE;
                  ready_q <= 1'b1;
               end
            end
            S_IDLE: begin
               if (bus.cmd_valid) begin
                  case (op)
                     OP_NOP:   ;
                     OP_ADD:   cur <= add_res;
                     OP_SUB:   cur <= sub_res;
                     OP_WRITE: cur <= arg;
                     OP_READ: begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= cur;
                     end
                     OP_RIGHT: begin
                        ptr_q   <= right_res;
                        if (PTR_WRAP == 0 && right_oor) err_q <= 1'b1;
                        state   <= S_FETCH_REQ;
                        ready_q <= 1'b0;
                     end
                     OP_LEFT: begin
                        ptr_q   <= left_res;
                        if (PTR_WRAP == 0 && left_oor) err_q <= 1'b1;
                        state   <= S_FETCH_REQ;
                        ready_q <= 1'b0;
                     end
                     OP_CLEAR: begin
                        state    <= S_CLEAR;
                        clr_addr <= '0;
                        cur      <= '0;
                        ready_q  <= 1'b0;
                     end
                     default: ;
                  endcase
               end
            end
            S_FETCH_REQ: begin
               state <= S_FETCH_CAP;
            end
            S_FETCH_CAP: begin
               cur     <= rd_data;
               state   <= S_IDLE;
               ready_q <= 1'b1;
            end
            default: begin
               state    <= S_CLEAR;
               clr_addr <= '0;
               ready_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cmd_ready = ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign ptr           = ptr_q;
   assign err           = err_q;
   assign cell_zero     = (cur == '0);

endmodule
`default_nettype wire

// File: tb/tb_tape_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_tape_engine
// Purpose  : Self-checking bench. Two engines run side by side on the same
//            command stream: one with wrapping pointer/cells, one with
//            saturating pointer/cells. A tape model of each is compared with
//            its engine every cycle, plus literal expectations for the
//            directed scenarios.
// Revision : 1.0  initial release
// ============================================================================
module tb_tape_engine;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 8;
   localparam int DEPTH  = 256;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic              cmd_valid;
   logic [2:0]        cmd_op;
   logic [DATA_W-1:0] cmd_arg;

   tape_engine_if #(.DATA_W(DATA_W)) bus_w ();
   tape_engine_if #(.DATA_W(DATA_W)) bus_s ();

   assign bus_w.cmd_valid = cmd_valid;
   assign bus_w.cmd_op    = cmd_op;
   assign bus_w.cmd_arg   = cmd_arg;
   assign bus_s.cmd_valid = cmd_valid;
   assign bus_s.cmd_op    = cmd_op;
   assign bus_s.cmd_arg   = cmd_arg;

   logic [ADDR_W-1:0] ptr_w, ptr_s;
   logic              zero_w, zero_s, err_w, err_s;

   tape_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PTR_WRAP(1), .CELL_WRAP(1)) dut_w (
      .clk(clk), .rst_n(rst_n), .bus(bus_w.slave),
      .ptr(ptr_w), .cell_zero(zero_w), .err(err_w));

   tape_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PTR_WRAP(0), .CELL_WRAP(0)) dut_s (
      .clk(clk), .rst_n(rst_n), .bus(bus_s.slave),
      .ptr(ptr_s), .cell_zero(zero_s), .err(err_s));

   // Model: index 0 = wrapping engine, index 1 = saturating engine.
   int m_tape [2][DEPTH];
   int m_ptr  [2];
   int m_cur  [2];
   int m_err  [2];
   int m_rspv [2];
   int m_rspd [2];
   int busy;      // cycles until the engine can accept again
   bit started = 1'b0;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_apply(input int m);
      bit wrap;
      int v;
      int p;
      wrap = (m == 0);
      case (int'(cmd_op))
         1: begin
            v = m_cur[m] + int'(cmd_arg);
            if (v > 255) v = wrap ? v - 256 : 255;
            m_cur[m] = v; m_tape[m][m_ptr[m]] = v;
         end
         2: begin
            v = m_cur[m] - int'(cmd_arg);
            if (v < 0) v = wrap ? v + 256 : 0;
            m_cur[m] = v; m_tape[m][m_ptr[m]] = v;
         end
         3: begin
            p = m_ptr[m] + int'(cmd_arg);
            if (p > DEPTH - 1) begin
               if (wrap) p = p - DEPTH;
               else begin p = DEPTH - 1; m_err[m] = 1; end
            end
            m_ptr[m] = p; m_cur[m] = m_tape[m][p]; busy = 2;
         end
         4: begin
            p = m_ptr[m] - int'(cmd_arg);
            if (p < 0) begin
               if (wrap) p = p + DEPTH;
               else begin p = 0; m_err[m] = 1; end
            end
            m_ptr[m] = p; m_cur[m] = m_tape[m][p]; busy = 2;
         end
         5: begin m_rspv[m] = 1; m_rspd[m] = m_cur[m]; end
         6: begin m_cur[m] = int'(cmd_arg); m_tape[m][m_ptr[m]] = int'(cmd_arg); end
         7: begin
            for (int a = 0; a < DEPTH; a++) m_tape[m][a] = 0;
            m_cur[m] = 0; busy = DEPTH;
         end
         default: ;
      endcase
   endtask

   task automatic model_step(output bit acc);
      acc = 1'b0;
      m_rspv[0] = 0; m_rspv[1] = 0;
      if (!rst_n) begin
         for (int m = 0; m < 2; m++) begin
            m_ptr[m] = 0; m_cur[m] = 0; m_err[m] = 0; m_rspd[m] = 0;
            for (int a = 0; a < DEPTH; a++) m_tape[m][a] = 0;
         end
         busy = DEPTH;
      end else if (busy > 0) begin
         busy--;
      end else if (cmd_valid) begin
         acc = 1'b1;
         model_apply(0);
         model_apply(1);
      end
   endtask

   task automatic check_all();
      bit rdy;
      rdy = (busy == 0) && rst_n;
      chk("ready_w", {31'd0, bus_w.cmd_ready}, {31'd0, rdy});
      chk("ready_s", {31'd0, bus_s.cmd_ready}, {31'd0, rdy});
      chk("ptr_w", {24'd0, ptr_w}, m_ptr[0]);
      chk("ptr_s", {24'd0, ptr_s}, m_ptr[1]);
      chk("err_w", {31'd0, err_w}, m_err[0]);
      chk("err_s", {31'd0, err_s}, m_err[1]);
      chk("rspv_w", {31'd0, bus_w.rsp_valid}, m_rspv[0]);
      chk("rspv_s", {31'd0, bus_s.rsp_valid}, m_rspv[1]);
      chk("rspd_w", {24'd0, bus_w.rsp_data}, m_rspd[0]);
      chk("rspd_s", {24'd0, bus_s.rsp_data}, m_rspd[1]);
      if (rdy) begin
         chk("zero_w", {31'd0, zero_w}, {31'd0, m_cur[0] == 0});
         chk("zero_s", {31'd0, zero_s}, {31'd0, m_cur[1] == 0});
      end
   endtask

   task automatic cyc(input bit v, input int op, input int arg, output bit acc);
      cmd_valid = v;
      cmd_op    = op[2:0];
      cmd_arg   = arg[7:0];
      @(posedge clk);
      #1;
      model_step(acc);
      if (started) check_all();
   endtask

   task automatic idle(input int n);
      bit a;
      for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, a);
   endtask

   // Holds the command valid until taken; waited = cycles spent not accepted.
   task automatic issue(input int op, input int arg, output int waited);
      bit acc;
      acc    = 1'b0;
      waited = 0;
      while (!acc && waited < 400) begin
         cyc(1'b1, op, arg, acc);
         if (!acc) waited++;
      end
      if (!acc) begin
         checks++; errors++;
         $display("FAIL issue_timeout op=%0d actual=not_accepted expected=accepted", op);
      end
      cmd_valid = 1'b0;
   endtask

   task automatic do_reset(input int n);
      rst_n   = 1'b0;
      started = 1'b1;
      idle(n);
      rst_n = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int n;
      int op;
      int arg;
      bit a;
      cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = '0;
      #2;
      do_reset(3);

      // 1: clear after reset takes DEPTH cycles
      n = 0;
      while (!bus_w.cmd_ready && n < 300) begin idle(1); n++; end
      chk("t1_ready_latency", n, 256);
      chk("t1_ptr", {24'd0, ptr_w}, 0);
      chk("t1_zero", {31'd0, zero_w}, 1);

      // 2: back-to-back adds then read
      issue(1, 3, w);
      issue(1, 5, w);
      chk("t2_b2b_wait", w, 0);
      issue(5, 0, w);
      chk("t2_rspv", {31'd0, bus_w.rsp_valid}, 1);
      chk("t2_rspd", {24'd0, bus_w.rsp_data}, 8);
      chk("t2_model_rspd", m_rspd[0], 8);
      chk("t2_zero", {31'd0, zero_w}, 0);

      // 3: write, move right, read, move back, read
      issue(6, 'h2A, w);
      issue(3, 1, w);
      issue(5, 0, w);
      chk("t3_right_hold", w, 2);
      chk("t3_rspd_right", {24'd0, bus_w.rsp_data}, 'h00);
      issue(4, 1, w);
      issue(5, 0, w);
      chk("t3_left_hold", w, 2);
      chk("t3_rspd_left", {24'd0, bus_w.rsp_data}, 'h2A);

      // 4: pointer wrap vs clamp at 0
      issue(4, 1, w);
      issue(0, 0, w);
      chk("t4_ptr_wrap", {24'd0, ptr_w}, 255);
      chk("t4_err_wrap", {31'd0, err_w}, 0);
      chk("t4_ptr_sat", {24'd0, ptr_s}, 0);
      chk("t4_err_sat", {31'd0, err_s}, 1);
      issue(3, 2, w);
      issue(0, 0, w);
      chk("t4_ptr_wrap2", {24'd0, ptr_w}, 1);
      chk("t4_ptr_sat2", {24'd0, ptr_s}, 2);
      chk("t4_err_sticky", {31'd0, err_s}, 1);

      // 5: cell wrap vs saturate
      issue(6, 0, w);
      issue(2, 1, w);
      issue(5, 0, w);
      chk("t5_sub_wrap", {24'd0, bus_w.rsp_data}, 'hFF);
      chk("t5_sub_sat", {24'd0, bus_s.rsp_data}, 'h00);
      issue(6, 'hF8, w);
      issue(1, 'h10, w);
      issue(5, 0, w);
      chk("t5_add_sat", {24'd0, bus_s.rsp_data}, 'hFF);
      chk("t5_add_wrap", {24'd0, bus_w.rsp_data}, 'h08);

      // 6: reset in the middle of a CLEAR command
      do_reset(2);
      issue(3, 4, w);
      issue(6, 7, w);
      issue(7, 0, w);
      idle(100);
      do_reset(1);
      issue(3, 4, w);
      chk("t6_clear_wait", w, 256);
      issue(5, 0, w);
      chk("t6_rspd", {24'd0, bus_w.rsp_data}, 0);
      chk("t6_ptr", {24'd0, ptr_w}, 4);
      chk("t6_ptr_s", {24'd0, ptr_s}, 4);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         op = $urandom_range(0, 7);
         if (op == 7 && $urandom_range(0, 9) != 0) op = 5;
         arg = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, 255);
         if ($urandom_range(0, 3) == 0) cyc(1'b0, $urandom_range(0, 7), $urandom_range(0, 255), a);
         issue(op, arg, w);
      end
      idle(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
